// File: rtl/piso_tx_sched.sv
//------------------------------------------------------------------------------
// piso_tx_sched : round-robin scheduler feeding one shared PISO, with framing
//                 and source-tag sideband aligned to the serial bit stream.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SRC_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     piso_load,
  output logic [WIDTH-1:0]         piso_data,
  output logic                     ser_valid,
  output logic                     ser_first,
  output logic                     ser_last,
  output logic [SRC_W-1:0]         ser_src,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] c_cnt_arb  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   c_num_req  = (PTR_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_n;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_ptr_n;
  logic [SRC_W-1:0]   r_src_next;
  logic [SRC_W-1:0]   w_src_next_n;

  logic [NUM_REQ-1:0] w_gnt_n;
  logic               w_load_n;
  logic [WIDTH-1:0]   w_data_n;
  logic               w_valid_n;
  logic               w_first_n;
  logic               w_last_n;
  logic [SRC_W-1:0]   w_ser_src_n;
  logic               w_busy_n;

  logic               w_arb;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W:0]     w_idx;
  logic [WIDTH-1:0]   w_word;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= c_num_req) begin
        w_idx = w_idx - c_num_req;
      end
      if (!w_found && req[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitration happens leaving IDLE, or one bit early in SHIFT so the
  // next load overlaps the last bit and the stream stays gapless.
  assign w_arb = (r_state == IDLE) || ((r_state == SHIFT) && (r_bit_cnt == c_cnt_arb));

  always_comb begin
    w_state_n    = r_state;
    w_bit_cnt_n  = r_bit_cnt;
    w_rr_ptr_n   = r_rr_ptr;
    w_src_next_n = r_src_next;
    w_gnt_n      = '0;
    w_load_n     = 1'b0;
    w_data_n     = piso_data;
    w_ser_src_n  = ser_src;

    if (w_arb && w_found) begin
      w_load_n       = 1'b1;
      w_gnt_n[w_win] = 1'b1;
      w_data_n       = w_word;
      w_src_next_n   = SRC_W'(w_win);
      w_rr_ptr_n     = (w_win == c_ptr_last) ? '0 : w_win + PTR_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_n = LOAD;
        end
      end
      LOAD: begin
        w_state_n   = SHIFT;
        w_bit_cnt_n = '0;
        w_ser_src_n = r_src_next;
      end
      SHIFT: begin
        if (r_bit_cnt == c_cnt_last) begin
          w_bit_cnt_n = '0;
          if (piso_load) begin
            w_ser_src_n = r_src_next;
          end else begin
            w_state_n = IDLE;
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n   = IDLE;
        w_bit_cnt_n = '0;
      end
    endcase

    w_valid_n = (w_state_n == SHIFT);
    w_first_n = w_valid_n && (w_bit_cnt_n == '0);
    w_last_n  = w_valid_n && (w_bit_cnt_n == c_cnt_last);
    w_busy_n  = (w_state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_src_next <= '0;
    end else begin
      r_state    <= w_state_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_src_next <= w_src_next_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      piso_load <= 1'b0;
      piso_data <= '0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      ser_src   <= '0;
      busy      <= 1'b0;
    end else begin
      gnt       <= w_gnt_n;
      piso_load <= w_load_n;
      piso_data <= w_data_n;
      ser_valid <= w_valid_n;
      ser_first <= w_first_n;
      ser_last  <= w_last_n;
      ser_src   <= w_ser_src_n;
      busy      <= w_busy_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_tx_sched.sv
//------------------------------------------------------------------------------
// tb_piso_tx_sched : scoreboard bench for piso_tx_sched with an MSB-first PISO.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_tx_sched;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0]   gnt;
  logic            piso_load;
  logic [W-1:0]    piso_data;
  logic            ser_valid;
  logic            ser_first;
  logic            ser_last;
  logic [SW-1:0]   ser_src;
  logic            busy;

  always #5 clk = ~clk;

  piso_tx_sched #(.NUM_REQ(NR), .WIDTH(W), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .piso_load (piso_load),
    .piso_data (piso_data),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .ser_src   (ser_src),
    .busy      (busy)
  );

  // Downstream serializer model: loads on piso_load, shifts MSB first.
  logic [W-1:0] sh;
  always @(posedge clk) begin
    if (piso_load) sh <= piso_data;
    else           sh <= {sh[W-2:0], 1'b0};
  end

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t ser_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] wdata[NR];
  int   wcnt[NR];
  int   last_run = 0;
  int   last_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected / not reached (t=%0t)", nm, $time);
  endtask

  function automatic logic [31:0] outs();
    return 32'({gnt, piso_load, piso_data, ser_valid, ser_first, ser_last, ser_src, busy});
  endfunction

  // Monitor: pops expectations whenever the DUT loads or shifts a bit.
  initial begin
    int   idx  = 0;
    int   run  = 0;
    int   gap  = 0;
    logic prev_load = 1'b0;
    exp_t e;
    exp_t cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        idx = 0; run = 0; gap = 0; prev_load = 1'b0;
      end else begin
        if (piso_load) begin
          chk("load_consecutive", 32'(prev_load), 32'd0);
          if (exp_q.size() == 0) begin
            fail("unexpected_load");
          end else begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(1) << e.src);
            chk("piso_data", 32'(piso_data), 32'(e.data));
            ser_q.push_back(e);
          end
        end else if (gnt != '0) begin
          fail("gnt_without_load");
        end
        prev_load = piso_load;

        if (ser_valid) begin
          if (idx == 0) begin
            last_gap = gap;
            if (ser_q.size() == 0) fail("unexpected_ser_valid");
            else                   cur = ser_q.pop_front();
          end
          chk("ser_first", 32'(ser_first), 32'(idx == 0));
          chk("ser_last", 32'(ser_last), 32'(idx == W-1));
          chk("ser_src", 32'(ser_src), 32'(cur.src));
          chk("serial_bit", 32'(sh[W-1]), 32'(cur.data[W-1-idx]));
          idx = (idx == W-1) ? 0 : idx + 1;
          run++;
          gap = 0;
        end else begin
          if (idx != 0) fail("ser_gap_mid_word");
          idx = 0;
          if (run > 0) last_run = run;
          run = 0;
          gap++;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = (wcnt[i] > 0);
      req_data[i*W +: W] = wdata[i];
    end
  endtask

  // Requester model: a grant consumes one word from that requester.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NR; i++) begin
      if (gnt[i] && wcnt[i] > 0) wcnt[i]--;
    end
    drive();
  endtask

  task automatic push(input int src, input logic [W-1:0] d);
    exp_t e;
    e.src  = SW'(src);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit all_done();
    bit ok = (busy == 1'b0) && (exp_q.size() == 0) && (ser_q.size() == 0);
    for (int i = 0; i < NR; i++) if (wcnt[i] != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_done(input int budget);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!all_done() && t < budget);
    if (!all_done()) fail("timeout_wait_done");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    ser_q.delete();
    for (int i = 0; i < NR; i++) wcnt[i] = 0;
    drive();
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    int t;
    for (int i = 0; i < NR; i++) begin
      wdata[i] = '0;
      wcnt[i]  = 0;
    end
    drive();

    // Reset then idle
    repeat (3) tick();
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outputs", outs(), 32'd0);
    end

    // Single word from requester 0
    wdata[0] = 8'h0F; wcnt[0] = 1; push(0, 8'h0F); drive();
    wait_done(40);
    chk("single_run_len", 32'(last_run), 32'd8);

    // Back-to-back round robin, requester 0 supplies two words
    do_reset();
    wdata[0] = 8'hFF; wdata[1] = 8'h00; wdata[2] = 8'hA5; wdata[3] = 8'h3C;
    wcnt[0] = 2; wcnt[1] = 1; wcnt[2] = 1; wcnt[3] = 1;
    push(0, 8'hFF); push(1, 8'h00); push(2, 8'hA5); push(3, 8'h3C); push(0, 8'hFF);
    drive();
    wait_done(100);
    chk("rr_run_len", 32'(last_run), 32'd40);

    // Pointer after grant to 2, then req = 0101
    do_reset();
    wdata[2] = 8'h5A; wcnt[2] = 1; push(2, 8'h5A); drive();
    wait_done(40);
    wdata[0] = 8'h11; wdata[2] = 8'h22; wcnt[0] = 1; wcnt[2] = 1;
    push(0, 8'h11); push(2, 8'h22); drive();
    wait_done(60);

    // Pointer after grant to 2, then req = 0111
    do_reset();
    wdata[2] = 8'h5A; wcnt[2] = 1; push(2, 8'h5A); drive();
    wait_done(40);
    wdata[0] = 8'h33; wdata[1] = 8'h44; wdata[2] = 8'h55;
    wcnt[0] = 1; wcnt[1] = 1; wcnt[2] = 1;
    push(0, 8'h33); push(1, 8'h44); push(2, 8'h55); drive();
    wait_done(80);

    // Late request rising during the ser_last cycle
    do_reset();
    wdata[0] = 8'hC3; wcnt[0] = 1; push(0, 8'hC3); drive();
    t = 0;
    do begin tick(); t++; end while (!ser_last && t < 30);
    if (!ser_last) fail("timeout_ser_last");
    wdata[1] = 8'h96; wcnt[1] = 1; push(1, 8'h96); drive();
    tick();
    chk("late_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("late_load", 32'(piso_load), 32'd1);
    wait_done(40);
    chk("late_gap", 32'(last_gap), 32'd2);

    // Asynchronous reset in the middle of a word
    do_reset();
    wdata[0] = 8'hE7; wdata[1] = 8'h81; wcnt[0] = 1; wcnt[1] = 1;
    push(0, 8'hE7); drive();
    t = 0;
    do begin tick(); t++; end while (!ser_first && t < 30);
    if (!ser_first) fail("timeout_ser_first");
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    exp_q.delete();
    ser_q.delete();
    push(1, 8'h81);
    repeat (2) tick();
    rst = 1'b1;
    wait_done(40);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("ser_q_empty", 32'(ser_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
